// File: rtl/tone_reg_sequencer_pkg.sv
// Shared definitions for the tone register sequencer: packet fields,
// assembly FSM states and datapath widths.
package tone_reg_sequencer_pkg;

  localparam int MASTER_COUNT_W = 10;
  localparam int ADDR_W         = 4;
  localparam int REG_DATA_W     = 16;
  localparam int WORD_W         = ADDR_W + REG_DATA_W;

  // Header byte: address in the low nibble, upper nibble reserved.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 3;

  // Header address that is consumed locally as a sticky-flag clear.
  localparam logic [ADDR_W-1:0] CMD_CLEAR_ADDR = 4'hF;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_HI  = 2'd1,
    S_LO  = 2'd2
  } asm_state_t;

endpackage

// File: rtl/reg_write_fifo.sv
// Synchronous FIFO holding assembled {addr, data} register writes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module reg_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_level == DEPTH[PTR_W:0]);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; reset empties the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tone_reg_sequencer.sv
// Host-side controller: master slot counter, 3-byte packet assembly,
// write FIFO and safe-window issue of register writes to the datapath.
module tone_reg_sequencer
  import tone_reg_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SAFE_START = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic                      host_strobe_in,
  input  logic                      host_first_in,
  input  logic [7:0]                host_byte_in,
  output logic [MASTER_COUNT_W-1:0] master_count_out,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [REG_DATA_W-1:0]     data_out,
  output logic                      data_valid_out,
  output logic                      busy_out,
  output logic                      overflow_out,
  output logic                      resync_out
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [MASTER_COUNT_W-1:0] SAFE_START_C = MASTER_COUNT_W'(SAFE_START);

  asm_state_t                r_state;
  logic [ADDR_W-1:0]         r_hdr_addr;
  logic [7:0]                r_hi_byte;
  logic [MASTER_COUNT_W-1:0] r_count;
  logic                      r_overflow;
  logic                      r_resync;
  logic                      r_busy;
  logic                      r_valid;
  logic [ADDR_W-1:0]         r_addr;
  logic [REG_DATA_W-1:0]     r_data;

  logic                      w_hdr_strobe;
  logic                      w_data_strobe;
  logic                      w_is_clear;
  logic                      w_push;
  logic [WORD_W-1:0]         w_push_word;
  logic [MASTER_COUNT_W-1:0] w_count_next;
  logic                      w_pop;
  logic                      w_push_acc;
  logic                      w_drop;
  logic                      w_open_next;
  logic [LVL_W-1:0]          w_level;
  logic [LVL_W-1:0]          w_level_next;
  logic [WORD_W-1:0]         w_fifo_rdata;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;

  assign w_hdr_strobe  = host_strobe_in & host_first_in;
  assign w_data_strobe = host_strobe_in & ~host_first_in;
  assign w_is_clear    = w_hdr_strobe &
                         (host_byte_in[HDR_ADDR_MSB:HDR_ADDR_LSB] == CMD_CLEAR_ADDR);
  assign w_push        = w_data_strobe & (r_state == S_LO);
  assign w_push_word   = {r_hdr_addr, r_hi_byte, host_byte_in};

  // The pop decision looks at the count that will be shown next to the write.
  assign w_count_next  = r_count + MASTER_COUNT_W'(1);
  assign w_pop         = ~w_fifo_empty & (w_count_next >= SAFE_START_C);
  assign w_push_acc    = w_push & (~w_fifo_full | w_pop);
  assign w_drop        = w_push & w_fifo_full & ~w_pop;
  assign w_level_next  = w_level + LVL_W'(w_push_acc) - LVL_W'(w_pop);

  // A packet is still open after this edge unless it ends or never starts.
  assign w_open_next   = host_strobe_in
                         ? (host_first_in ? ~w_is_clear : (r_state == S_HI))
                         : (r_state != S_HDR);

  reg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst_n (reset_n_in),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  // Free-running frame slot counter, wraps 1023 -> 0.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_count <= '0;
    else             r_count <= w_count_next;
  end

  // Packet assembly FSM; a header always restarts assembly.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state    <= S_HDR;
      r_hdr_addr <= '0;
      r_hi_byte  <= '0;
    end else if (host_strobe_in) begin
      if (host_first_in) begin
        r_hdr_addr <= host_byte_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
        r_state    <= w_is_clear ? S_HDR : S_HI;
      end else begin
        case (r_state)
          S_HDR:   r_state <= S_HDR;
          S_HI: begin
            r_hi_byte <= host_byte_in;
            r_state   <= S_LO;
          end
          S_LO:    r_state <= S_HDR;
          default: r_state <= S_HDR;
        endcase
      end
    end
  end

  // Sticky error flags; the local clear command takes priority over any set.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_overflow <= 1'b0;
      r_resync   <= 1'b0;
    end else if (w_is_clear) begin
      r_overflow <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      if (w_drop)                             r_overflow <= 1'b1;
      if (w_hdr_strobe && r_state != S_HDR)   r_resync   <= 1'b1;
    end
  end

  // Busy reflects the state that holds after this edge.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_busy <= 1'b0;
    else             r_busy <= w_open_next | (w_level_next != '0);
  end

  // Datapath write port; address and data hold between writes.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_addr <= w_fifo_rdata[WORD_W-1:REG_DATA_W];
        r_data <= w_fifo_rdata[REG_DATA_W-1:0];
      end
    end
  end

  assign master_count_out = r_count;
  assign addr_out         = r_addr;
  assign data_out         = r_data;
  assign data_valid_out   = r_valid;
  assign busy_out         = r_busy;
  assign overflow_out     = r_overflow;
  assign resync_out       = r_resync;

endmodule

// File: tb/tb_tone_reg_sequencer.sv
// Bench for tone_reg_sequencer: packet vector table plus hand-written
// sequences for overflow, resync and reset-with-pending-writes.
module tb_tone_reg_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        host_strobe_in;
  logic        host_first_in;
  logic [7:0]  host_byte_in;
  logic [9:0]  master_count_out;
  logic [3:0]  addr_out;
  logic [15:0] data_out;
  logic        data_valid_out;
  logic        busy_out;
  logic        overflow_out;
  logic        resync_out;

  tone_reg_sequencer #(
    .FIFO_DEPTH (4),
    .SAFE_START (16)
  ) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .host_strobe_in   (host_strobe_in),
    .host_first_in    (host_first_in),
    .host_byte_in     (host_byte_in),
    .master_count_out (master_count_out),
    .addr_out         (addr_out),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .busy_out         (busy_out),
    .overflow_out     (overflow_out),
    .resync_out       (resync_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cnt;
  } wr_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          done_cnt;
    int          exp_cnt;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  localparam int NV = 9;

  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  sb[$];
  wr_t  obs[64];
  int   obs_wr = 0;
  int   obs_rd = 0;
  vec_t vecs[NV];

  // Write monitor: records every datapath write with the count shown alongside it.
  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) begin
      obs[obs_wr % 64] = '{addr_out, data_out, int'(master_count_out)};
      obs_wr = obs_wr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_service();
    wr_t o;
    wr_t e;
    while (obs_rd != obs_wr) begin
      o = obs[obs_rd % 64];
      obs_rd++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h count=%0d, expected no write",
                 o.addr, o.data, o.cnt);
      end else begin
        e = sb.pop_front();
        check("wr_addr",  32'(o.addr), 32'(e.addr));
        check("wr_data",  32'(o.data), 32'(e.data));
        check("wr_count", o.cnt,       e.cnt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    sb_service();
  endtask

  task automatic send_byte(input logic first, input logic [7:0] b);
    host_strobe_in = 1'b1;
    host_first_in  = first;
    host_byte_in   = b;
    tick();
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (int'(master_count_out) != target && n < 2100) begin
      tick();
      n++;
    end
    if (n >= 2100) check("wait_count_timeout", n, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad_cnt;
    int bad_busy;
    int bad_valid;
    int w0;

    vecs[0] = '{8'h02, 8'h12, 8'h34,  100,  102, 4'h2, 16'h1234};
    vecs[1] = '{8'h02, 8'h12, 8'h34, 1020, 1022, 4'h2, 16'h1234};
    vecs[2] = '{8'h02, 8'h12, 8'h34,    3,   16, 4'h2, 16'h1234};
    vecs[3] = '{8'h0A, 8'hFF, 8'h00,  500,  502, 4'hA, 16'hFF00};
    vecs[4] = '{8'h0E, 8'h80, 8'h01, 1022,   16, 4'hE, 16'h8001};
    vecs[5] = '{8'hF1, 8'h5A, 8'hA5,  200,  202, 4'h1, 16'h5AA5};
    vecs[6] = '{8'h07, 8'h00, 8'h01,   14,   16, 4'h7, 16'h0001};
    vecs[7] = '{8'h08, 8'hC3, 8'h3C,   15,   17, 4'h8, 16'hC33C};
    vecs[8] = '{8'h09, 8'h77, 8'h88, 1021, 1023, 4'h9, 16'h7788};

    reset_n_in     = 1'b0;
    host_strobe_in = 1'b0;
    host_first_in  = 1'b0;
    host_byte_in   = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;

    // Reset state
    check("rst_count",    32'(master_count_out), 0);
    check("rst_valid",    32'(data_valid_out),   0);
    check("rst_busy",     32'(busy_out),         0);
    check("rst_overflow", 32'(overflow_out),     0);
    check("rst_resync",   32'(resync_out),       0);
    check("rst_addr",     32'(addr_out),         0);
    check("rst_data",     32'(data_out),         0);

    // Idle frame: count sequence 0..1023,0 with no writes and not busy
    reset_n_in = 1'b1;
    check("rel_count0", 32'(master_count_out), 0);
    bad_cnt = 0; bad_busy = 0; bad_valid = 0;
    for (int i = 1; i <= 1025; i++) begin
      tick();
      if (master_count_out !== 10'(i % 1024)) bad_cnt++;
      if (busy_out !== 1'b0)                  bad_busy++;
      if (data_valid_out !== 1'b0)            bad_valid++;
    end
    check("idle_count_seq_errors", bad_cnt,   0);
    check("idle_busy_cycles",      bad_busy,  0);
    check("idle_valid_cycles",     bad_valid, 0);
    check("idle_write_count",      obs_wr,    0);

    // Single packets at assorted completion counts
    for (int v = 0; v < NV; v++) begin
      wait_count((vecs[v].done_cnt + 1022) % 1024);
      send_byte(1'b1, vecs[v].hdr);
      send_byte(1'b0, vecs[v].hi);
      sb.push_back('{vecs[v].exp_addr, vecs[v].exp_data, vecs[v].exp_cnt});
      send_byte(1'b0, vecs[v].lo);
      host_strobe_in = 1'b0;
      check("busy_after_pkt", 32'(busy_out), 1);
      wait_drain(1100);
      check("busy_after_issue", 32'(busy_out),       0);
      check("valid_one_cycle",  32'(data_valid_out), 0);
      check("addr_hold",        32'(addr_out),       32'(vecs[v].exp_addr));
      check("data_hold",        32'(data_out),       32'(vecs[v].exp_data));
    end

    // Five packets before the window with a 4-deep FIFO: fifth is dropped
    wait_count(0);
    w0 = obs_wr;
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, 8'(i));
      send_byte(1'b0, 8'(8'h10 + i));
      if (i < 4) sb.push_back('{4'(i), {8'(8'h10 + i), 8'(8'hC0 + i)}, 16 + i});
      send_byte(1'b0, 8'(8'hC0 + i));
    end
    host_strobe_in = 1'b0;
    check("ovf_count_at_set", 32'(master_count_out), 15);
    check("ovf_set",          32'(overflow_out),     1);
    check("ovf_no_resync",    32'(resync_out),       0);
    check("ovf_busy",         32'(busy_out),         1);
    wait_drain(100);
    repeat (30) tick();
    check("ovf_sticky",       32'(overflow_out),     1);
    check("ovf_write_count",  obs_wr - w0,           4);
    send_byte(1'b1, 8'h0F);
    host_strobe_in = 1'b0;
    check("clr_overflow",     32'(overflow_out),     0);
    check("clr_busy",         32'(busy_out),         0);
    repeat (20) tick();
    check("clr_no_write",     obs_wr - w0,           4);

    // Header mid-packet restarts assembly and flags resync
    wait_count(300);
    w0 = obs_wr;
    send_byte(1'b1, 8'h05);
    send_byte(1'b0, 8'hAA);
    check("resync_before", 32'(resync_out), 0);
    send_byte(1'b1, 8'h06);
    check("resync_set",    32'(resync_out), 1);
    send_byte(1'b0, 8'hBE);
    sb.push_back('{4'h6, 16'hBEEF, 306});
    send_byte(1'b0, 8'hEF);
    host_strobe_in = 1'b0;
    wait_drain(100);
    repeat (10) tick();
    check("resync_write_count", obs_wr - w0,        1);
    check("resync_sticky",      32'(resync_out),    1);
    send_byte(1'b1, 8'h0F);
    host_strobe_in = 1'b0;
    check("resync_cleared",     32'(resync_out),    0);

    // Reset while in S_LO with two writes queued
    wait_count(0);
    send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h11);
    send_byte(1'b1, 8'h02); send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h22);
    send_byte(1'b1, 8'h03); send_byte(1'b0, 8'h33);
    host_strobe_in = 1'b0;
    check("pre_rst_busy", 32'(busy_out), 1);
    w0 = obs_wr;
    reset_n_in = 1'b0;
    #1;
    check("async_rst_count",  32'(master_count_out), 0);
    check("async_rst_busy",   32'(busy_out),         0);
    check("async_rst_valid",  32'(data_valid_out),   0);
    check("async_rst_addr",   32'(addr_out),         0);
    check("async_rst_data",   32'(data_out),         0);
    check("async_rst_resync", 32'(resync_out),       0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    check("rel2_count0", 32'(master_count_out), 0);
    tick();
    check("rel2_count1", 32'(master_count_out), 1);
    repeat (1100) tick();
    check("post_rst_no_write", obs_wr - w0,     0);
    check("post_rst_busy",     32'(busy_out),   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_reg_sequencer.md
# tone_reg_sequencer

Host-side controller for the four-channel tone datapath. It owns the free-running 10-bit master count that sequences the DDS, DCA and mixer slots. It assembles 3-byte host packets into register writes, buffers them in a small FIFO, and issues them to the datapath's `addr/data/data_valid` port only inside a safe window of the sample frame. This keeps phase-increment, volume and wave-type updates from landing mid-accumulate or mid-mix.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: register-write FIFO entries; power of two, ≥2.
- `SAFE_START`, 16: first master-count value at which a write may be presented; writes are never presented at counts 0..`SAFE_START`-1.

Ports:
- `clk_in`  in  1  system clock.
- `reset_n_in`  in  1  asynchronous, active-low reset.
- `host_strobe_in`  in  1  one-cycle byte-valid strobe.
- `host_first_in`  in  1  qualifies the strobed byte as a packet header.
- `host_byte_in`  in  8  host byte.
- `master_count_out`  out  10  frame slot counter to the datapath.
- `addr_out`  out  4  register address to the datapath.
- `data_out`  out  16  register data to the datapath.
- `data_valid_out`  out  1  one-cycle write strobe to the datapath.
- `busy_out`  out  1  packet in assembly or FIFO non-empty.
- `overflow_out`  out  1  sticky: a completed packet was dropped because the FIFO was full.
- `resync_out`  out  1  sticky: a header arrived mid-packet.

## Operation
- Master count: increments every cycle and wraps 1023→0.
- Packet format:
  - Header byte, with `host_first_in`=1: `[3:0]` address, `[7:4]` reserved and ignored.
  - Byte 2: `data[15:8]`.
  - Byte 3: `data[7:0]`.
- Assembly FSM states:
  - `S_HDR`: strobe with first=1 → latch address, go to `S_HI`. Strobe with first=0 → ignored.
  - `S_HI`: strobe with first=0 → latch the high byte, go to `S_LO`.
  - `S_LO`: strobe with first=0 → form the word, push it to the FIFO, go to `S_HDR`.
  - Strobe with first=1 in `S_HI` or `S_LO`: discard the partial packet, set `resync_out`, treat the byte as a new header, go to `S_HI`.
- Address 0xF is a local command. Its header clears `overflow_out` and `resync_out`, stays in `S_HDR`, and is never forwarded.
- Addresses 0x0–0xE are forwarded unmodified; the datapath decodes them.
- FIFO push:
  - Accepted if not full, or if full with a pop in the same cycle (count unchanged).
  - Otherwise the word is dropped and `overflow_out` is set.
  - Order is strictly FIFO.
- Issue rule: pop one entry per cycle when the FIFO is non-empty and the master count presented alongside the write is in [`SAFE_START`, 1023]. Up to 1008 writes per frame (default `SAFE_START`).
- `busy_out` = (FSM ≠ `S_HDR`) | FIFO non-empty.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all outputs 0, FSM → `S_HDR`, FIFO emptied, count = 0.
  - Reset mid-packet or with the FIFO full loses all pending writes.
  - The first count after release is 1.
- All outputs are registered.
- `addr_out`/`data_out` hold their last issued value when `data_valid_out`=0.
- Latency, with the count in the window and the FIFO empty: last data byte strobed in cycle N → push at edge N → `data_valid_out` high in cycle N+2.
- No same-cycle bypass through an empty FIFO.
- Push outside the window: the write is held. It is presented in the cycle where `master_count_out` = `SAFE_START`; a FIFO entry waiting at count 1023 is presented at count `SAFE_START` of the next frame.
- Simultaneous events:
  - A header and a pop in the same cycle are independent.
  - An address-0xF header in the same cycle as an overflow drop: the clear wins and the flag ends at 0.
- Sticky flags are set the cycle after the causing strobe.

## Structure
- Shared package holds:
  - Packet-field constants: header address field, `CMD_CLEAR_ADDR` = 4'hF.
  - Assembly FSM state enum.
  - `MASTER_COUNT_W` = 10.
- One sub-module, `reg_write_fifo`: synchronous FIFO, 20-bit entries (`addr`+`data`), parameterised depth, push/pop/full/empty.
- The FSM, counter and issue logic live in the top.

## Test plan
- Reset release, no host traffic → `master_count_out` 0,1,2,…,1023,0; `data_valid_out` never asserts; `busy_out`=0.
- Packet {first:0x02, 0x12, 0x34} completed at count 100 → single `data_valid_out` at count 102 with `addr_out`=2, `data_out`=0x1234; `busy_out` falls the cycle after the strobe.
- Same packet completed at count 1020 → the write presents at count 1022; completed at count 3 → the write presents exactly at count 16.
- Five packets (addresses 0..4) during counts 0..15 with `FIFO_DEPTH`=4 → addresses 0..3 issue back-to-back at counts 16..19; the 5th is dropped, `overflow_out`=1; header 0x0F → `overflow_out`=0, with no datapath write.
- Header 0x05, 0xAA, then header 0x06, 0xBE, 0xEF → `resync_out`=1; one write only: `addr_out`=6, `data_out`=0xBEEF.
- Assert `reset_n_in` while in `S_LO` with 2 entries queued → outputs 0 immediately; after release, no write issues in the next 1024 cycles.
